// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and helpers for the instruction-fetch stage.
//   fetch_state_t     : fetch FSM states (BOOT, RUN, HALT)
//   HALT_WORD_DEFAULT : default instruction encoding that stops fetching
//   addr_bits()       : log2 of the instruction memory depth, used to build
//                       the word-address mask applied to the PC
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    // Number of address bits needed for a memory of 'depth' words.
    function automatic int unsigned addr_bits(input int unsigned depth);
        int unsigned bits;
        bits = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(depth)) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/fetch_stage_pc_unit.sv
// pc_unit: program counter register and next-PC selection for fetch_stage.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset (pc <= RESET_PC)
//   run            : FSM is in RUN
//   halt_mode      : FSM is in HALT (only a branch may move the PC)
//   stall          : hold request from the hazard unit
//   branch_taken   : redirect request from execute
//   branch_target  : redirect word address (masked to the memory depth)
//   pc             : current PC, drives the instruction memory address
//   advance        : this cycle is a normal fetch (capture + increment)
//   redirect       : this cycle loads branch_target
module pc_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     N        = 32,
    parameter int unsigned     M        = 1024,
    parameter logic [N-1:0]    RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         run,
    input  logic         halt_mode,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    output logic [N-1:0] pc,
    output logic         advance,
    output logic         redirect
);

    localparam int unsigned  AW        = addr_bits(M);
    localparam logic [N-1:0] ADDR_MASK = N'((64'd1 << AW) - 64'd1);

    logic [N-1:0] pc_next;

    // Priority: branch > stall > normal. BOOT (neither run nor halt_mode)
    // holds the PC; HALT ignores stall and only honours a branch.
    always_comb begin
        redirect = (run | halt_mode) & branch_taken;
        advance  = run & ~branch_taken & ~stall;
        pc_next  = (pc + N'(1)) & ADDR_MASK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= branch_target & ADDR_MASK;
        end else if (advance) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the hybrid ARM/MIPS pipeline.
// Owns the PC (via pc_unit), drives the word-addressed instruction memory
// and loads the IF/ID register. Handles stall, branch redirect and halt.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   stall          : hold PC and IF/ID register
//   branch_taken   : redirect request (wins over stall, also leaves HALT)
//   branch_target  : redirect word address
//   imem_address   : instruction memory address (= pc)
//   imem_data      : combinational instruction memory read data
//   instr_out      : IF/ID instruction word
//   pc_out         : IF/ID PC of instr_out
//   valid_out      : IF/ID entry holds a real instruction
//   halted         : fetch stopped on HALT_WORD
//   fetch_count    : (FETCH_PERF_EN only) number of valid captures
//   stall_count    : (FETCH_PERF_EN only) number of stalled RUN cycles
// Optional feature macro: FETCH_PERF_EN
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned  N         = 32,
    parameter int unsigned  M         = 1024,
    parameter logic [N-1:0] RESET_PC  = '0,
    parameter logic [N-1:0] HALT_WORD = N'(HALT_WORD_DEFAULT)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    output logic [N-1:0] imem_address,
    input  logic [N-1:0] imem_data,
    output logic [N-1:0] instr_out,
    output logic [N-1:0] pc_out,
    output logic         valid_out,
    output logic         halted
`ifdef FETCH_PERF_EN
    ,
    output logic [N-1:0] fetch_count,
    output logic [N-1:0] stall_count
`endif
);

    fetch_state_t state;
    logic [N-1:0] pc;
    logic         advance;
    logic         redirect;

    pc_unit #(
        .N        (N),
        .M        (M),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (state == RUN),
        .halt_mode     (state == HALT),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc),
        .advance       (advance),
        .redirect      (redirect)
    );

    assign imem_address = pc;

    // FSM and IF/ID register. halted rises on the first HALT cycle, together
    // with valid_out dropping, one cycle after HALT_WORD itself is delivered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BOOT;
            instr_out <= '0;
            pc_out    <= '0;
            valid_out <= 1'b0;
            halted    <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                end
                RUN: begin
                    if (redirect) begin
                        valid_out <= 1'b0;
                    end else if (advance) begin
                        instr_out <= imem_data;
                        pc_out    <= pc;
                        valid_out <= 1'b1;
                        if (imem_data == HALT_WORD) begin
                            state <= HALT;
                        end
                    end
                end
                HALT: begin
                    valid_out <= 1'b0;
                    if (redirect) begin
                        halted <= 1'b0;
                        state  <= RUN;
                    end else begin
                        halted <= 1'b1;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (advance) begin
                fetch_count <= fetch_count + N'(1);
            end
            if ((state == RUN) && stall && !branch_taken) begin
                stall_count <= stall_count + N'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed steps, a reference model of the
// fetch FSM, and a scoreboard of expected IF/ID captures.
module tb_fetch_stage;

    localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;
    localparam logic [31:0] MASK   = 32'h0000_03FF;
    localparam int S_BOOT = 0;
    localparam int S_RUN  = 1;
    localparam int S_HALT = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] imem_address;
    logic [31:0] imem_data;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic        halted;

    logic        stall16 = 1'b0;
    logic        branch16 = 1'b0;
    logic [31:0] target16 = '0;
    logic [31:0] imem_address16;
    logic [31:0] imem_data16;
    logic [31:0] instr_out16;
    logic [31:0] pc_out16;
    logic        valid_out16;
    logic        halted16;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
    logic [31:0] fetch_count16;
    logic [31:0] stall_count16;
`endif

    logic [31:0] mem [1024];

    assign imem_data   = mem[imem_address[9:0]];
    assign imem_data16 = 32'hB000_0000 | imem_address16;

    always #5 clk = ~clk;

    fetch_stage #(.N(32), .M(1024)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_address  (imem_address),
        .imem_data     (imem_data),
        .instr_out     (instr_out),
        .pc_out        (pc_out),
        .valid_out     (valid_out),
        .halted        (halted)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count   (fetch_count),
        .stall_count   (stall_count)
`endif
    );

    fetch_stage #(.N(32), .M(16)) dut16 (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall16),
        .branch_taken  (branch16),
        .branch_target (target16),
        .imem_address  (imem_address16),
        .imem_data     (imem_data16),
        .instr_out     (instr_out16),
        .pc_out        (pc_out16),
        .valid_out     (valid_out16),
        .halted        (halted16)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count   (fetch_count16),
        .stall_count   (stall_count16)
`endif
    );

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [31:0] pc_m;
    int          st_m;
    logic        v_m;
    logic        h_m;
    int          fetches_m;
    int          stalls_m;
    sb_t         sbq [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        pc_m      = 32'd0;
        st_m      = S_BOOT;
        v_m       = 1'b0;
        h_m       = 1'b0;
        fetches_m = 0;
        stalls_m  = 0;
        sbq.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},  imem_address, 32'd0);
        check({tag, "_instr"}, instr_out, 32'd0);
        check({tag, "_pcout"}, pc_out, 32'd0);
        check({tag, "_valid"}, 32'(valid_out), 32'd0);
        check({tag, "_halt"},  32'(halted), 32'd0);
    endtask

    // One clock: drive inputs, advance the model, then compare after the edge.
    task automatic cycle(input logic s, input logic b, input logic [31:0] t);
        bit  fresh;
        sb_t e;
        fresh = 0;
        stall = s;
        branch_taken = b;
        branch_target = t;
        case (st_m)
            S_BOOT: st_m = S_RUN;
            S_RUN: begin
                if (b) begin
                    pc_m = t & MASK;
                    v_m  = 1'b0;
                end else if (s) begin
                    stalls_m++;
                end else begin
                    e.pc    = pc_m;
                    e.instr = mem[pc_m[9:0]];
                    sbq.push_back(e);
                    fresh = 1;
                    v_m   = 1'b1;
                    fetches_m++;
                    if (e.instr == HALT_W) st_m = S_HALT;
                    pc_m = (pc_m + 32'd1) & MASK;
                end
            end
            default: begin
                v_m = 1'b0;
                if (b) begin
                    pc_m = t & MASK;
                    st_m = S_RUN;
                    h_m  = 1'b0;
                end else begin
                    h_m = 1'b1;
                end
            end
        endcase
        @(posedge clk);
        #1;
        check("imem_address", imem_address, pc_m);
        check("valid_out", 32'(valid_out), 32'(v_m));
        check("halted", 32'(halted), 32'(h_m));
        if (fresh) begin
            e = sbq.pop_front();
            check("instr_out", instr_out, e.instr);
            check("pc_out", pc_out, e.pc);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + 32'(i);
        reset_model();

        // Reset state
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Free run: BOOT then A0..A3, continue to pc=5
        cycle(1'b1, 1'b0, '0);            // BOOT ignores stall
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0);

        // Stall three cycles at pc=5, then release
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0);
        check("stall_hold_pcout", pc_out, 32'd4);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);           // pc now 7

        // Branch wins over stall; upper target bits are ignored
        cycle(1'b1, 1'b1, 32'h40);
        cycle(1'b0, 1'b0, '0);
        check("branch_pcout", pc_out, 32'h40);
        cycle(1'b0, 1'b1, 32'hFFFF_0041);
        check("mask_addr", imem_address, 32'h41);
        cycle(1'b0, 1'b0, '0);

        // Halt on mem[2], stay frozen, then leave via branch
        mem[2] = HALT_W;
        cycle(1'b0, 1'b1, 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);
        check("halt_word_pcout", pc_out, 32'd2);
        for (int i = 0; i < 10; i++) cycle(1'(i % 2), 1'b0, '0);
        check("halt_frozen_pc", imem_address, 32'd3);
        mem[2] = 32'hA000_0002;
        cycle(1'b1, 1'b1, 32'd0);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);

        // Mid-run asynchronous reset at pc=9
        cycle(1'b0, 1'b1, 32'd7);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        check("pre_reset_pc", imem_address, 32'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;

        // Performance counters: 4 fetches, 2 stalls
        cycle(1'b1, 1'b0, '0);            // BOOT: stall not counted
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
`ifdef FETCH_PERF_EN
        check("fetch_count", fetch_count, 32'(fetches_m));
        check("stall_count", stall_count, 32'(stalls_m));
        cycle(1'b1, 1'b1, 32'h20);       // branch+stall is not a stall cycle
        check("stall_count_branch", stall_count, 32'(stalls_m));
`endif

        // Reset again, then 16-deep wrap on dut16
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset2");
`ifdef FETCH_PERF_EN
        check("fetch_count_rst", fetch_count, 32'd0);
        check("stall_count_rst", stall_count, 32'd0);
`endif
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b0, '0);
        check("wrap_addr_15", imem_address16, 32'd15);
        cycle(1'b0, 1'b0, '0);
        check("wrap_addr_0", imem_address16, 32'd0);
        check("wrap_pcout_15", pc_out16, 32'd15);
        check("wrap_instr_15", instr_out16, 32'hB000_000F);
        cycle(1'b0, 1'b0, '0);
        check("wrap_addr_1", imem_address16, 32'd1);
        branch16 = 1'b1;
        target16 = 32'h13;
        cycle(1'b0, 1'b0, '0);
        branch16 = 1'b0;
        check("wrap_mask_target", imem_address16, 32'd3);

        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the hybrid ARM/MIPS pipeline. It sits directly upstream of the word-addressed instruction memory. It owns the program counter and drives the memory address. It captures the returned instruction word into the IF/ID pipeline register and handles stall, branch redirect and halt. The decode stage consumes instr_out, pc_out and valid_out.

Parameters:
N, 32, data/address width in bits
M, 1024, instruction memory depth in words; must be a power of two
RESET_PC, 0, word address loaded into the PC on reset
HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetching

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
stall  input  1  hold PC and IF/ID register (hazard unit)
branch_taken  input  1  redirect request from the execute stage
branch_target  input  N  word address of the redirect target
imem_address  output  N  address to instruction memory, equals pc
imem_data  input  N  combinational read data from instruction memory
instr_out  output  N  IF/ID instruction word
pc_out  output  N  IF/ID PC of instr_out
valid_out  output  1  IF/ID entry holds a real instruction
halted  output  1  fetch stopped on HALT_WORD

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc=RESET_PC.
  - instr_out=0, pc_out=0, valid_out=0, halted=0.
  - State=BOOT.
  - Any in-flight operation is discarded.
- Addressing:
  - PC is a word address. imem_address=pc, combinational.
  - pc_next=(pc+1) mod M; pc=M-1 wraps to 0.
  - branch_target is masked to its low log2(M) bits. Upper bits are ignored.
- FSM states: BOOT, RUN, HALT.
  - BOOT: one cycle; valid_out stays 0 and pc holds. Next state is RUN unconditionally, and stall is ignored.
  - RUN: per-cycle priority is branch_taken > stall > normal.
    - branch_taken=1: pc<=target and valid_out<=0, which squashes the wrong-path word. This applies even if stall=1.
    - stall=1, no branch: pc, instr_out, pc_out and valid_out all hold.
    - Normal: instr_out<=imem_data, pc_out<=pc, valid_out<=1, pc<=pc_next.
    - Halt: if the word captured on a normal cycle equals HALT_WORD, the next state is HALT. The HALT_WORD itself is delivered with valid_out=1 that cycle.
  - HALT: halted=1 and pc frozen.
    - valid_out<=0 on the first HALT cycle and stays 0.
    - branch_taken in HALT: pc<=target, halted<=0, next state RUN. This lets an older in-flight branch override the halt.
    - stall in HALT has no effect.
- Latency: the instruction at address A appears on instr_out one cycle after pc=A with no stall.
- No combinational path exists from stall or branch_taken to any IF/ID output.

Optional Feature:
FETCH_PERF_EN
- Defined:
  - Adds output fetch_count (N bits), incremented on every cycle valid_out is loaded with 1.
  - Adds output stall_count (N bits), incremented on every RUN cycle with stall=1 and branch_taken=0.
  - Both counters reset to 0 and wrap on overflow.
- Undefined: both ports and their counters are absent. Core behaviour is identical.

Decomposition:
- fetch_pkg holds:
  - the fetch_state_t enum {BOOT, RUN, HALT};
  - the HALT_WORD default constant;
  - the localparam function for log2(M) address masking.
- One sub-module, pc_unit, holds the PC register and next-PC mux (wrap, mask, branch/stall priority). fetch_stage holds the FSM and the IF/ID register.

Test Plan:
1. Reset then free run with mem[0..3]=A0,A1,A2,A3:
   - Cycle 1 (BOOT): valid_out=0.
   - Cycles 2–5: instr_out=A0..A3, pc_out=0..3, valid_out=1.
2. Stall at pc=5 for 3 cycles:
   - imem_address stays 5 and instr_out/pc_out hold the word from address 4.
   - On release, the word from address 5 appears with pc_out=5.
3. Branch vs stall: branch_taken=1, branch_target=0x40 together with stall=1 at pc=7:
   - Next cycle: pc=0x40 and valid_out=0.
   - Following cycle: pc_out=0x40.
4. Wrap: M=16, start at pc=15 with no branch; address sequence must be 15, 0, 1. A branch_target of 0x13 must give pc=3.
5. Halt: mem[2]=HALT_WORD.
   - The HALT_WORD appears with valid_out=1 and pc_out=2.
   - Then halted=1, valid_out=0, and pc frozen for 10 cycles.
   - A following branch_taken to 0 clears halted and fetching resumes from address 0.
6. Reset mid-run plus counters:
   - Assert rst_n=0 asynchronously between clock edges at pc=9. All outputs clear immediately and pc=RESET_PC.
   - With FETCH_PERF_EN: after 4 valid fetches and 2 stalls, fetch_count=4 and stall_count=2; both return to 0 on reset.
